// File: rtl/bsearch_cmp_ctrl_pkg.sv
// Shared types and constants for the binary-search comparator initiator.
// Holds the FSM state encoding and the {l,e,h} flag-decode constants.
package bsearch_cmp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        PROBE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Legal one-hot {l,e,h} responses; every other value is illegal.
    localparam logic [2:0] FLAG_L = 3'b100;
    localparam logic [2:0] FLAG_E = 3'b010;
    localparam logic [2:0] FLAG_H = 3'b001;

endpackage

// File: rtl/bsearch_cmp_ctrl.sv
// Binary-search initiator facing an N-bit magnitude comparator.
// Narrows the inclusive range [lo_in, hi_in] by probing midpoints and
// consuming the comparator's less/equal/greater flags.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, lo_in, hi_in search request and inclusive bounds (IDLE only)
//   probe, probe_vld    operand offered to the comparator
//   cmp_vld, l, e, h    comparator response (probe <, ==, > target)
//   busy, done          activity level and one-cycle end-of-search pulse
//   found, err, result  search outcome, held until the next start
//   iters               compares consumed, held until the next start
module bsearch_cmp_ctrl
    import bsearch_cmp_ctrl_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  lo_in,
    input  logic [N-1:0]  hi_in,
    output logic [N-1:0]  probe,
    output logic          probe_vld,
    input  logic          cmp_vld,
    input  logic          l,
    input  logic          e,
    input  logic          h,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic          err,
    output logic [N-1:0]  result,
    output logic [CW-1:0] iters
);

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  lo_q;
    logic [N-1:0]  hi_q;
    logic [N-1:0]  mid_q;
    logic [2:0]    flags_c;
    logic          busy_nx;
    logic          probe_vld_nx;
    logic          done_nx;

    assign flags_c = {l, e, h};
    assign probe   = mid_q;

    // State register plus registered status outputs aligned with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            probe_vld <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            busy      <= busy_nx;
            probe_vld <= probe_vld_nx;
            done      <= done_nx;
        end
    end

    // Next-state logic; bound checks stop the search before mid+1 / mid-1 wrap.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (lo_in > hi_in) ? DONE : CALC;
                end
            end
            CALC: state_nx = PROBE;
            PROBE: begin
                if (cmp_vld) begin
                    case (flags_c)
                        FLAG_E:  state_nx = DONE;
                        FLAG_L:  state_nx = (mid_q == hi_q) ? DONE : CALC;
                        FLAG_H:  state_nx = (mid_q == lo_q) ? DONE : CALC;
                        default: state_nx = DONE;
                    endcase
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state, then registered above.
    always_comb begin
        busy_nx      = 1'b0;
        probe_vld_nx = 1'b0;
        done_nx      = 1'b0;
        case (state_nx)
            CALC:  busy_nx = 1'b1;
            PROBE: begin
                busy_nx      = 1'b1;
                probe_vld_nx = 1'b1;
            end
            DONE: begin
                busy_nx = 1'b1;
                done_nx = 1'b1;
            end
            default: ;
        endcase
    end

    // Search datapath: bounds, midpoint and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q   <= '0;
            hi_q   <= '0;
            mid_q  <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            iters  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lo_q   <= lo_in;
                        hi_q   <= hi_in;
                        found  <= 1'b0;
                        err    <= 1'b0;
                        result <= '0;
                        iters  <= '0;
                    end
                end
                CALC: begin
                    // Offset form keeps the sum inside N bits.
                    mid_q <= lo_q + ((hi_q - lo_q) >> 1);
                end
                PROBE: begin
                    if (cmp_vld) begin
                        iters <= iters + CW'(1);
                        case (flags_c)
                            FLAG_E: begin
                                found  <= 1'b1;
                                result <= mid_q;
                            end
                            FLAG_L: begin
                                if (mid_q != hi_q) lo_q <= mid_q + N'(1);
                            end
                            FLAG_H: begin
                                if (mid_q != lo_q) hi_q <= mid_q - N'(1);
                            end
                            default: begin
                                err   <= 1'b1;
                                found <= 1'b0;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bsearch_cmp_ctrl.sv
// Self-checking bench for bsearch_cmp_ctrl (N=8) against a comparator
// responder with random response delay and a behavioural search model.
module tb_bsearch_cmp_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  lo_in;
    logic [N-1:0]  hi_in;
    logic [N-1:0]  probe;
    logic          probe_vld;
    logic          cmp_vld;
    logic          l;
    logic          e;
    logic          h;
    logic          busy;
    logic          done;
    logic          found;
    logic          err;
    logic [N-1:0]  result;
    logic [CW-1:0] iters;

    bsearch_cmp_ctrl #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lo_in     (lo_in),
        .hi_in     (hi_in),
        .probe     (probe),
        .probe_vld (probe_vld),
        .cmp_vld   (cmp_vld),
        .l         (l),
        .e         (e),
        .h         (h),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .err       (err),
        .result    (result),
        .iters     (iters)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Comparator responder: hidden target, random wait before cmp_vld.
    logic [N-1:0] target;
    logic         bad_mode;
    logic [2:0]   bad_flags;
    int           dly_min;
    int           dly_max;
    int           dly;
    int           cnt;

    assign cmp_vld = probe_vld && (cnt >= dly);

    always_comb begin
        if (bad_mode) begin
            {l, e, h} = bad_flags;
        end else begin
            l = (probe < target);
            e = (probe == target);
            h = (probe > target);
        end
    end

    always @(posedge clk) begin
        if (rst || !probe_vld || cmp_vld) begin
            cnt <= 0;
            dly <= $urandom_range(dly_max, dly_min);
        end else begin
            cnt <= cnt + 1;
        end
    end

    int done_count = 0;
    always @(negedge clk) if (done) done_count++;

    // Behavioural model: plain-integer binary search over [lo, hi].
    int exp_q[$];
    bit exp_err;

    task automatic model(input int lo, input int hi, input int tgt, input bit bad);
        int a;
        int b;
        int m;
        exp_q.delete();
        exp_err = 1'b0;
        if (lo > hi) return;
        a = lo;
        b = hi;
        for (int k = 0; k < 64; k++) begin
            m = (a + b) / 2;
            exp_q.push_back(m);
            if (bad) begin
                exp_err = 1'b1;
                return;
            end
            if (m == tgt) return;
            if (m < tgt) begin
                if (m == b) return;
                a = m + 1;
            end else begin
                if (m == a) return;
                b = m - 1;
            end
        end
    endtask

    // Issue start at the current negedge (an IDLE cycle) and check the outcome.
    task automatic run_search(input string name, input int lo, input int hi, input int tgt,
                              input int dmin, input int dmax, input bit bad,
                              input logic [2:0] bflags);
        int  cyc;
        int  done_cyc;
        bit  got_done;
        bit  saw_vld;
        bit  in_range;
        int  obs_q[$];
        int  ov;
        target    = N'(tgt);
        dly_min   = dmin;
        dly_max   = dmax;
        bad_mode  = bad;
        bad_flags = bflags;
        model(lo, hi, tgt, bad);
        in_range  = !bad && (lo <= hi) && (tgt >= lo) && (tgt <= hi);
        lo_in = N'(lo);
        hi_in = N'(hi);
        start = 1'b1;
        cyc = 0; done_cyc = 0; got_done = 1'b0; saw_vld = 1'b0;
        while (!got_done && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (probe_vld) saw_vld = 1'b1;
            if (probe_vld && cmp_vld) obs_q.push_back(int'(probe));
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
        end
        check({name, "_done_seen"}, 32'(got_done), 32'd1);
        check({name, "_busy_at_done"}, 32'(busy), 32'd1);
        check({name, "_found"}, 32'(found), 32'(in_range));
        check({name, "_result"}, 32'(result), in_range ? 32'(tgt) : 32'd0);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_iters"}, 32'(iters), 32'(exp_q.size()));
        check({name, "_nprobes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            ov = (i < obs_q.size()) ? obs_q[i] : -1;
            check($sformatf("%s_probe%0d", name, i), 32'(ov), 32'(exp_q[i]));
        end
        if (lo > hi) begin
            check({name, "_done_latency"}, 32'(done_cyc), 32'd1);
            check({name, "_no_probe_vld"}, 32'(saw_vld), 32'd0);
        end
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_probe"}, 32'(probe), 32'd0);
        check({name, "_probe_vld"}, 32'(probe_vld), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_found"}, 32'(found), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_result"}, 32'(result), 32'd0);
        check({name, "_iters"}, 32'(iters), 32'd0);
    endtask

    initial begin
        int w;
        int done_base;
        int rlo;
        int rhi;
        int rtg;
        logic [2:0] bflags;
        bit  rbad;
        logic [2:0] illegal [5];
        illegal[0] = 3'b000; illegal[1] = 3'b011; illegal[2] = 3'b101;
        illegal[3] = 3'b110; illegal[4] = 3'b111;

        rst = 1'b1; start = 1'b0; lo_in = '0; hi_in = '0;
        target = '0; bad_mode = 1'b0; bad_flags = 3'b000;
        dly_min = 0; dly_max = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_search("t1", 0, 255, 100, 0, 0, 1'b0, 3'b000);
        check("t1_iters_const", 32'(iters), 32'd8);
        run_search("t2", 0, 255, 255, 0, 3, 1'b0, 3'b000);
        check("t2_iters_const", 32'(iters), 32'd9);
        check("t2_result_const", 32'(result), 32'd255);
        run_search("t3", 5, 10, 3, 0, 2, 1'b0, 3'b000);
        check("t3_iters_const", 32'(iters), 32'd2);
        run_search("t4", 0, 255, 50, 0, 2, 1'b1, 3'b101);
        check("t4_err_const", 32'(err), 32'd1);
        check("t4_iters_const", 32'(iters), 32'd1);
        bad_mode = 1'b0;
        run_search("t5", 10, 5, 7, 0, 0, 1'b0, 3'b000);
        check("t5_iters_const", 32'(iters), 32'd0);

        // Abort while a 5-cycle compare is outstanding.
        target = 8'd100; dly_min = 5; dly_max = 5; bad_mode = 1'b0;
        lo_in = 8'd0; hi_in = 8'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!probe_vld && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("abort_probe_vld", 32'(probe_vld), 32'd1);
        @(negedge clk);
        done_base = done_count;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(done_base));
        run_search("t6", 0, 255, 100, 0, 2, 1'b0, 3'b000);
        check("t6_iters_const", 32'(iters), 32'd8);

        for (int t = 0; t < 30; t++) begin
            rlo = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) rhi = int'($urandom_range(0, 255));
            else rhi = rlo + int'($urandom_range(0, 255 - rlo));
            if ($urandom_range(0, 3) != 0 && rlo <= rhi) rtg = int'($urandom_range(rhi, rlo));
            else rtg = int'($urandom_range(0, 255));
            rbad   = ($urandom_range(0, 9) == 0);
            bflags = illegal[$urandom_range(0, 4)];
            run_search($sformatf("rnd%0d", t), rlo, rhi, rtg, 0, 3, rbad, bflags);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
